// File: rtl/obi_dma_scratch_pkg.sv
// obi_dma_scratch_pkg: shared types and helpers for the DMA scratch responder.
//   ERR_RDATA_DEFAULT : read data returned for out-of-range reads
//   resp_stage_t      : one response pipeline slot {valid, rdata}
//   byte_merge()      : byte-enable merge of write data into an old word
package obi_dma_scratch_pkg;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC_AB1E;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } resp_stage_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// obi_pkg: OBI request/response bundles shared by the DMA external ports.
//   obi_req_t  : req, we, be[3:0], addr[31:0], wdata[31:0]
//   obi_resp_t : gnt, rvalid, rdata[31:0]
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_dma_scratch_responder_delay_line.sv
// obi_resp_delay_line: LATENCY-deep shift register of response slots.
//   clk_i, rst_ni : clock, asynchronous active-low reset (flushes all slots)
//   stage_i       : slot entering the line (valid = grant this cycle)
//   stage_o       : oldest slot, drives rvalid/rdata
// The last slot only loads data from a valid predecessor, so rdata holds its
// last returned value while rvalid is low.
module obi_resp_delay_line
    import obi_dma_scratch_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  resp_stage_t stage_i,
    output resp_stage_t stage_o
);

    resp_stage_t pipe_r [LATENCY];
    resp_stage_t feed_s [LATENCY];

    // Input of every slot: the new entry for slot 0, the previous slot otherwise.
    always_comb begin
        feed_s[0] = stage_i;
        for (int k = 1; k < int'(LATENCY); k++) begin
            feed_s[k] = pipe_r[k-1];
        end
    end

    // Shift all slots each cycle; last slot keeps its data across empty slots.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                pipe_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                pipe_r[k].valid <= feed_s[k].valid;
                if ((k < int'(LATENCY) - 1) || feed_s[k].valid) begin
                    pipe_r[k].rdata <= feed_s[k].rdata;
                end else begin
                    pipe_r[k].rdata <= pipe_r[k].rdata;
                end
            end
        end
    end

    assign stage_o = pipe_r[LATENCY-1];

endmodule

// File: rtl/obi_dma_scratch_responder.sv
// obi_dma_scratch_responder: terminates one DMA external OBI master port with
// a word-addressed scratch memory and a fixed response latency.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   obi_req_i      : OBI request (req, we, be, addr, wdata)
//   obi_resp_o     : OBI response (gnt combinational, rvalid/rdata delayed)
//   stall_i        : withholds gnt while high
//   rd_count_o     : granted reads since reset (wraps)
//   wr_count_o     : granted writes since reset (wraps)
//   err_count_o    : granted out-of-range accesses (saturates)
module obi_dma_scratch_responder
    import obi_pkg::*;
    import obi_dma_scratch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  obi_req_t    obi_req_i,
    output obi_resp_t   obi_resp_o,
    input  logic        stall_i,
    output logic [31:0] rd_count_o,
    output logic [31:0] wr_count_o,
    output logic [15:0] err_count_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    logic              grant_s;
    logic [31:0]       offset_s;
    logic              in_range_s;
    logic [AW-1:0]     word_idx_s;
    logic [31:0]       rd_data_s;
    resp_stage_t       stage_in_s;
    resp_stage_t       stage_out_s;

    logic [31:0]       mem_r [DEPTH];
    logic [31:0]       rd_cnt_r;
    logic [31:0]       wr_cnt_r;
    logic [15:0]       err_cnt_r;

    // Grant and address decode; offset wraps so addresses below BASE_ADDR are out of range.
    always_comb begin
        grant_s    = obi_req_i.req & ~stall_i;
        offset_s   = obi_req_i.addr - BASE_ADDR;
        in_range_s = (offset_s < SPAN);
        word_idx_s = offset_s[AW+1:2];
    end

    // Read data is taken from the array in the grant cycle; writes answer zero.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (grant_s && !obi_req_i.we) begin
            if (in_range_s) begin
                rd_data_s = mem_r[word_idx_s];
            end else begin
                rd_data_s = ERR_RDATA;
            end
        end else begin
            rd_data_s = 32'h0000_0000;
        end
        stage_in_s.valid = grant_s;
        stage_in_s.rdata = rd_data_s;
    end

    // Scratch memory: zeroed on reset, byte-lane write on in-range granted writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (grant_s && obi_req_i.we && in_range_s) begin
            mem_r[word_idx_s] <= byte_merge(mem_r[word_idx_s], obi_req_i.wdata, obi_req_i.be);
        end
    end

    // Access counters: wrapping read/write counts, saturating error count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_r  <= 32'h0000_0000;
            wr_cnt_r  <= 32'h0000_0000;
            err_cnt_r <= 16'h0000;
        end else if (grant_s) begin
            if (obi_req_i.we) begin
                wr_cnt_r <= wr_cnt_r + 32'd1;
            end else begin
                rd_cnt_r <= rd_cnt_r + 32'd1;
            end
            if (!in_range_s && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    obi_resp_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay_line (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stage_i (stage_in_s),
        .stage_o (stage_out_s)
    );

    // Response assembly: gnt is combinational, rvalid/rdata come from the delay line.
    always_comb begin
        obi_resp_o.gnt    = grant_s;
        obi_resp_o.rvalid = stage_out_s.valid;
        obi_resp_o.rdata  = stage_out_s.rdata;
    end

    assign rd_count_o  = rd_cnt_r;
    assign wr_count_o  = wr_cnt_r;
    assign err_count_o = err_cnt_r;

endmodule

// File: tb/tb_obi_dma_scratch_responder.sv
// Directed testbench for obi_dma_scratch_responder (LATENCY=3, DEPTH=256,
// BASE_ADDR=0x1000). A per-cycle monitor checks rvalid/rdata against a queue
// of expected responses; directed checks cover the hand-computed values.
module tb_obi_dma_scratch_responder;
    import obi_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 3;
    localparam logic [31:0] ERRD  = 32'hBADC_AB1E;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_resp_t;

    logic        clk;
    logic        rst_ni;
    obi_req_t    req_s;
    obi_resp_t   resp_s;
    logic        stall_s;
    logic [31:0] rd_count_s;
    logic [31:0] wr_count_s;
    logic [15:0] err_count_s;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    exp_resp_t   exp_q [$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_rd = 32'h0;
    logic [31:0] exp_wr = 32'h0;
    logic [15:0] exp_err = 16'h0;
    logic [31:0] last_rdata = 32'h0;
    logic        force_now = 1'b0;

    obi_dma_scratch_responder #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .ERR_RDATA (ERRD)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .obi_req_i   (req_s),
        .obi_resp_o  (resp_s),
        .stall_i     (stall_s),
        .rd_count_o  (rd_count_s),
        .wr_count_o  (wr_count_s),
        .err_count_o (err_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard: record each grant with its expected data and due cycle.
    always @(posedge clk) begin
        logic [31:0] off;
        logic        inr;
        int          idx;
        exp_resp_t   e;
        if (!rst_ni) begin
            exp_q.delete();
            for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
            exp_rd  = 32'h0;
            exp_wr  = 32'h0;
            exp_err = 16'h0;
        end else begin
            if (force_now) exp_rd = 32'hFFFF_FFFF;
            if (req_s.req && !stall_s) begin
                off = req_s.addr - BASE;
                inr = (off < 32'(DEPTH * 4));
                idx = int'(off[9:2]);
                e.due = cyc + int'(LAT);
                if (req_s.we) begin
                    e.data = 32'h0;
                    exp_wr = exp_wr + 32'd1;
                    if (inr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (req_s.be[b]) model_mem[idx][8*b +: 8] = req_s.wdata[8*b +: 8];
                        end
                    end
                end else begin
                    e.data = inr ? model_mem[idx] : ERRD;
                    exp_rd = exp_rd + 32'd1;
                end
                if (!inr && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
                exp_q.push_back(e);
            end
        end
        cyc = cyc + 1;
    end

    // Monitor: rvalid must be high exactly on due cycles, low otherwise.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("rvalid", {31'h0, resp_s.rvalid}, 32'h1);
            chk("rdata", resp_s.rdata, exp_q[0].data);
            last_rdata = resp_s.rdata;
            void'(exp_q.pop_front());
        end else begin
            chk("rvalid_idle", {31'h0, resp_s.rvalid}, 32'h0);
        end
    end

    task automatic issue(input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_s.req   = 1'b1;
        req_s.we    = we;
        req_s.be    = be;
        req_s.addr  = addr;
        req_s.wdata = wdata;
        stall_s     = 1'b0;
        #1 chk("gnt", {31'h0, resp_s.gnt}, 32'h1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_s.req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_rd"}, rd_count_s, exp_rd);
        chk({tag, "_wr"}, wr_count_s, exp_wr);
        chk({tag, "_err"}, {16'h0, err_count_s}, {16'h0, exp_err});
    endtask

    initial begin
        rst_ni  = 1'b0;
        req_s   = '0;
        stall_s = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", {31'h0, resp_s.gnt}, 32'h0);
        chk("rst_rvalid", {31'h0, resp_s.rvalid}, 32'h0);
        chk("rst_rdata", resp_s.rdata, 32'h0);
        chk("rst_rd", rd_count_s, 32'h0);
        chk("rst_wr", wr_count_s, 32'h0);
        chk("rst_err", {16'h0, err_count_s}, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Full-word write then readback
        issue(1'b1, 4'hF, BASE + 32'd8, 32'hDEAD_BEEF);
        issue(1'b0, 4'hF, BASE + 32'd8, 32'h0);
        idle(LAT + 1);
        chk("beef_rd", last_rdata, 32'hDEAD_BEEF);
        chk("beef_rdcnt", rd_count_s, 32'd1);
        chk("beef_wrcnt", wr_count_s, 32'd1);

        // Partial byte-enable write to a zeroed word
        issue(1'b1, 4'b0101, BASE + 32'd16, 32'h1122_3344);
        issue(1'b0, 4'hF, BASE + 32'd16, 32'h0);
        idle(LAT + 1);
        chk("be_rd", last_rdata, 32'h0022_0044);

        // Fill 16 words, then a 16-read burst with a 2-cycle stall in the middle
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'hF, BASE + 32'(4 * i), 32'hA000_0000 + 32'(i));
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                req_s.req  = 1'b1;
                req_s.we   = 1'b0;
                req_s.addr = BASE + 32'(4 * i);
                stall_s    = 1'b1;
                repeat (2) begin
                    #1 chk("stall_gnt", {31'h0, resp_s.gnt}, 32'h0);
                    @(negedge clk);
                end
            end
            issue(1'b0, 4'hF, BASE + 32'(4 * i), 32'h0);
        end
        idle(LAT + 1);
        chk("burst_last", last_rdata, 32'hA000_000F);
        chk("burst_rdcnt", rd_count_s, 32'd18);
        chk("burst_wrcnt", wr_count_s, 32'd18);

        // Out-of-range read and write; top in-range word must stay zero
        issue(1'b0, 4'hF, BASE + 32'(DEPTH * 4), 32'h0);
        idle(LAT + 1);
        chk("oor_rd", last_rdata, ERRD);
        issue(1'b1, 4'hF, BASE - 32'd4, 32'h1234_5678);
        issue(1'b0, 4'hF, BASE + 32'(DEPTH * 4 - 4), 32'h0);
        idle(LAT + 1);
        chk("oor_wr_nochange", last_rdata, 32'h0);
        chk("oor_errcnt", {16'h0, err_count_s}, 32'd2);
        check_counts("oor");

        // Reset one cycle before two in-flight read responses
        issue(1'b0, 4'hF, BASE + 32'd8, 32'h0);
        issue(1'b0, 4'hF, BASE + 32'd12, 32'h0);
        req_s.req = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        chk("mid_rst_rd", rd_count_s, 32'h0);
        chk("mid_rst_wr", wr_count_s, 32'h0);
        chk("mid_rst_err", {16'h0, err_count_s}, 32'h0);
        idle(LAT + 2);
        issue(1'b0, 4'hF, BASE + 32'd8, 32'h0);
        idle(LAT + 1);
        chk("mid_rst_mem", last_rdata, 32'h0);
        check_counts("post_rst");

        // Read counter wrap from a preloaded 2^32-1
        force dut.rd_cnt_r = 32'hFFFF_FFFF;
        force_now = 1'b1;
        @(negedge clk);
        force_now = 1'b0;
        release dut.rd_cnt_r;
        #1 chk("preload_rd", rd_count_s, 32'hFFFF_FFFF);
        @(negedge clk);
        issue(1'b0, 4'hF, BASE, 32'h0);
        idle(LAT + 1);
        chk("wrap_rd", rd_count_s, 32'h0);
        check_counts("final");
        chk("drain", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
